csr_trap_ctrl: RTL
==================

Name: csr_trap_ctrl

Overview:
- Sequencer directly upstream of the CSR register file; sits between the decode/execute stage and the CSR file.
- Accepts one CSR or SYSTEM request at a time and performs read-modify-write for CSRRW/S/C and their immediate forms.
- Sequences ecall, illegal-instruction and mret into the CSR file's 2-bit trap port, then issues a PC redirect to mtvec or mepc.
- Stalls the pipeline while busy.

Parameters:
- XLEN, 64, CSR data width; matches `CSR_WIDTH.
- CSR_AW, 12, CSR address width; matches `CSR_ADDR_WIDTH.
- PC_W, 64, PC width; matches `INSTR_MEM_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI, 000 SYSTEM, 100 reserved.
- req_sys  in  2  used when funct3=000: 01 ecall, 10 illegal, 11 mret, 00 treated as illegal.
- req_addr  in  CSR_AW  CSR address.
- req_src  in  XLEN  rs1 value.
- req_zimm  in  5  immediate operand.
- req_rs1_zero  in  1  rs1 index (or zimm) is zero.
- req_pc  in  PC_W  PC of the instruction.
- csr_read_addr  out  CSR_AW  to CSR file.
- csr_read_data  in  XLEN  combinational read from CSR file.
- csr_we  out  1  CSR file write enable.
- csr_write_addr  out  CSR_AW  CSR file write address.
- csr_write_data  out  XLEN  CSR file write data.
- trap  out  2  01 ecall, 10 illegal, 11 mret, 00 none.
- trap_pc  out  PC_W  PC handed to the CSR file with trap.
- rsp_valid  out  1  one-cycle pulse; CSR op complete.
- rsp_rd_data  out  XLEN  old CSR value, for rd.
- redirect_valid  out  1  one-cycle pulse.
- redirect_pc  out  PC_W  redirect target.
- busy  out  1  pipeline stall.

Behaviour:
- States: IDLE, READ, WRITE, TRAP, MRET, VECTOR. Encoding is 3-bit binary.
- Reset: state=IDLE. All outputs 0 except req_ready=1. Internal latches (addr, op, src, old value, pc, kind) are cleared.
- IDLE: req_ready=1, busy=0. Handshake is req_valid&&req_ready; request fields are latched on that edge.
  - funct3 in {001,010,011,101,110,111} -> READ.
  - ecall, illegal, sys=00, or funct3=100 -> TRAP.
  - mret -> MRET.
- READ: csr_read_addr=latched addr; old value is registered -> WRITE.
- WRITE: one cycle.
  - rsp_valid=1 and rsp_rd_data=old.
  - Operand: src for RW/RS/RC; zero-extended zimm for immediate forms.
  - RW: new=operand. RS: new=old|operand. RC: new=old&~operand.
  - csr_we=1 with csr_write_addr=addr and new value, except RS/RC/RSI/RCI with req_rs1_zero=1, which do not write. RW/RWI always write.
  - Next state: IDLE.
- Latency: accept at edge T; rsp_valid and write at cycle T+2; next request accepted at T+3.
- TRAP: one cycle. trap=01 for ecall, 10 for all illegal cases; trap_pc=latched pc; csr_we=0 -> VECTOR.
- MRET: one cycle. trap=11; csr_we=0 -> VECTOR.
- VECTOR:
  - csr_read_addr=0x305 (mtvec) after ecall/illegal, 0x341 (mepc) after mret.
  - redirect_valid=1. redirect_pc = csr_read_data & ~3 for mtvec (direct mode); csr_read_data unchanged for mepc.
  - Next state: IDLE. No rsp_valid for SYSTEM requests.
- Invariants:
  - csr_we and trap are never nonzero in the same cycle.
  - At most one of rsp_valid and redirect_valid is high per cycle.
  - busy = (state != IDLE); req_ready = !busy.
- Reset mid-operation: FSM returns to IDLE immediately; no write or trap is issued afterwards. Writes are single-cycle and therefore atomic.
- req_valid while busy: ignored. The source holds the request until it is accepted.

Optional Feature:
- Macro: CSR_ACCESS_CHECK_EN.
- Defined: in IDLE, a CSR-op request whose addr is not one of 0x300, 0x305, 0x341, 0x342 goes to TRAP with trap=10; no read, no write, no rsp_valid.
- Undefined: all addresses proceed normally. Unimplemented CSRs read 0 and writes have no effect.

Decomposition:
- Shared header (alongside common.vh): funct3 op codes, req_sys codes, trap codes, state encodings.
- CSR address constants come from the existing `CSR_* macros.
- Sub-module csr_rmw_alu: combinational operand select, RW/RS/RC compute, and the write-suppress flag.

Test Plan:
- CSRRW 0x305 with src=0x8000_0100 and mtvec=0 -> at T+2: rsp_rd_data=0, csr_we=1, write data 0x8000_0100; busy for 2 cycles.
- CSRRS 0x300 with rs1_zero=1 and mstatus=0x88 -> rsp_rd_data=0x88, csr_we stays 0.
- CSRRCI 0x300 with zimm=0x08 and mstatus=0x88 -> write 0x80.
- ecall at pc=0x1000 with mtvec=0x2003 -> trap=01 and trap_pc=0x1000 for one cycle, then redirect_valid with redirect_pc=0x2000.
- mret with mepc=0x1004 -> trap=11 for one cycle, then redirect_pc=0x1004.
- rst_n low during READ -> state IDLE, csr_we never asserted, req_ready=1.
- With CSR_ACCESS_CHECK_EN: CSRRW 0x7C0 -> trap=10, no write.

Source files
------------

// File: rtl/csr_trap_ctrl_pkg.sv
// Shared definitions for the CSR/trap sequencer: instruction field codes,
// trap codes, FSM state encoding and the machine-mode CSR addresses.
package csr_trap_ctrl_pkg;

    localparam int CSR_ADDR_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_TRAP   = 3'd3,
        ST_MRET   = 3'd4,
        ST_VECTOR = 3'd5
    } state_t;

    localparam logic [2:0] F3_SYSTEM = 3'b000;
    localparam logic [2:0] F3_RW     = 3'b001;
    localparam logic [2:0] F3_RS     = 3'b010;
    localparam logic [2:0] F3_RC     = 3'b011;
    localparam logic [2:0] F3_RSV    = 3'b100;
    localparam logic [2:0] F3_RWI    = 3'b101;
    localparam logic [2:0] F3_RSI    = 3'b110;
    localparam logic [2:0] F3_RCI    = 3'b111;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [1:0] SYS_NONE    = 2'b00;
    localparam logic [1:0] SYS_ECALL   = 2'b01;
    localparam logic [1:0] SYS_ILLEGAL = 2'b10;
    localparam logic [1:0] SYS_MRET    = 2'b11;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ECALL   = 2'b01;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b10;
    localparam logic [1:0] TRAP_MRET    = 2'b11;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // True for the CSRs the register file actually implements
    function automatic logic csr_is_implemented(input logic [11:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
               (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
    endfunction

endpackage

// File: rtl/csr_trap_ctrl_rmw_alu.sv
// Read-modify-write datapath: picks the register or immediate operand,
// computes the RW/RS/RC result and flags set/clear forms with a zero source,
// which must leave the CSR untouched.
module csr_rmw_alu
    import csr_trap_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old_value,
    input  logic [XLEN-1:0] src,
    input  logic [4:0]      zimm,
    input  logic            rs1_zero,
    output logic [XLEN-1:0] new_value,
    output logic            write_suppress
);

    logic [XLEN-1:0] operand;

    // Operand select, new-value compute and write suppression
    always_comb begin
        operand        = funct3[2] ? {{(XLEN-5){1'b0}}, zimm} : src;
        new_value      = old_value;
        write_suppress = 1'b0;
        case (funct3[1:0])
            OP_RW: new_value = operand;
            OP_RS: begin
                new_value      = old_value | operand;
                write_suppress = rs1_zero;
            end
            OP_RC: begin
                new_value      = old_value & ~operand;
                write_suppress = rs1_zero;
            end
            default: new_value = old_value;
        endcase
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// CSR / trap sequencer between execute and the CSR register file.
// Runs CSR read-modify-write operations and sequences ecall, illegal and
// mret through the CSR file trap port followed by a PC redirect.
// Optional build macro: CSR_ACCESS_CHECK_EN (unimplemented CSR addresses
// raise an illegal-instruction trap instead of being accessed).
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CSR_AW = CSR_ADDR_W,
    parameter int PC_W   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [1:0]        req_sys,
    input  logic [CSR_AW-1:0] req_addr,
    input  logic [XLEN-1:0]   req_src,
    input  logic [4:0]        req_zimm,
    input  logic              req_rs1_zero,
    input  logic [PC_W-1:0]   req_pc,
    output logic [CSR_AW-1:0] csr_read_addr,
    input  logic [XLEN-1:0]   csr_read_data,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_write_addr,
    output logic [XLEN-1:0]   csr_write_data,
    output logic [1:0]        trap,
    output logic [PC_W-1:0]   trap_pc,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rd_data,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              busy
);

    state_t            state;
    state_t            state_next;

    logic [CSR_AW-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   src_q;
    logic [4:0]        zimm_q;
    logic              rs1_zero_q;
    logic [PC_W-1:0]   pc_q;
    logic [1:0]        kind_q;
    logic [XLEN-1:0]   old_q;

    logic              accept;
    logic              req_is_csr;
    logic              req_is_mret;
    logic              access_ok;
    logic [1:0]        req_kind;
    logic [XLEN-1:0]   alu_new;
    logic              alu_suppress;

    assign accept      = req_valid && (state == ST_IDLE);
    assign req_is_csr  = (req_funct3[1:0] != 2'b00);
    assign req_is_mret = (req_funct3 == F3_SYSTEM) && (req_sys == SYS_MRET);

`ifdef CSR_ACCESS_CHECK_EN
    assign access_ok = csr_is_implemented(req_addr);
`else
    assign access_ok = 1'b1;
`endif

    // Classify the incoming request into the trap it would raise
    always_comb begin
        if (req_is_mret)
            req_kind = TRAP_MRET;
        else if ((req_funct3 == F3_SYSTEM) && (req_sys == SYS_ECALL))
            req_kind = TRAP_ECALL;
        else
            req_kind = TRAP_ILLEGAL;
    end

    csr_rmw_alu #(.XLEN(XLEN)) u_alu (
        .funct3         (funct3_q),
        .old_value      (old_q),
        .src            (src_q),
        .zimm           (zimm_q),
        .rs1_zero       (rs1_zero_q),
        .new_value      (alu_new),
        .write_suppress (alu_suppress)
    );

    // Capture the request on handshake and the old CSR value during READ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            funct3_q   <= '0;
            src_q      <= '0;
            zimm_q     <= '0;
            rs1_zero_q <= 1'b0;
            pc_q       <= '0;
            kind_q     <= TRAP_NONE;
            old_q      <= '0;
        end else begin
            if (accept) begin
                addr_q     <= req_addr;
                funct3_q   <= req_funct3;
                src_q      <= req_src;
                zimm_q     <= req_zimm;
                rs1_zero_q <= req_rs1_zero;
                pc_q       <= req_pc;
                kind_q     <= req_kind;
            end
            if (state == ST_READ)
                old_q <= csr_read_data;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_is_csr && access_ok)
                        state_next = ST_READ;
                    else if (req_is_mret)
                        state_next = ST_MRET;
                    else
                        state_next = ST_TRAP;
                end
            end
            ST_READ:   state_next = ST_WRITE;
            ST_WRITE:  state_next = ST_IDLE;
            ST_TRAP:   state_next = ST_VECTOR;
            ST_MRET:   state_next = ST_VECTOR;
            ST_VECTOR: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output decode per state
    always_comb begin
        req_ready      = (state == ST_IDLE);
        busy           = (state != ST_IDLE);
        csr_read_addr  = '0;
        csr_we         = 1'b0;
        csr_write_addr = '0;
        csr_write_data = '0;
        trap           = TRAP_NONE;
        trap_pc        = '0;
        rsp_valid      = 1'b0;
        rsp_rd_data    = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            ST_READ: csr_read_addr = addr_q;
            ST_WRITE: begin
                rsp_valid      = 1'b1;
                rsp_rd_data    = old_q;
                csr_we         = !alu_suppress;
                csr_write_addr = addr_q;
                csr_write_data = alu_new;
            end
            ST_TRAP: begin
                trap    = kind_q;
                trap_pc = pc_q;
            end
            ST_MRET: begin
                trap    = TRAP_MRET;
                trap_pc = pc_q;
            end
            ST_VECTOR: begin
                redirect_valid = 1'b1;
                if (kind_q == TRAP_MRET) begin
                    csr_read_addr = CSR_AW'(CSR_MEPC);
                    redirect_pc   = PC_W'(csr_read_data);
                end else begin
                    csr_read_addr = CSR_AW'(CSR_MTVEC);
                    redirect_pc   = PC_W'(csr_read_data & ~XLEN'(3));
                end
            end
            default: ;
        endcase
    end

endmodule
